// File: rtl/can_pkg.sv
// can_pkg: shared types and constants for the CAN bit timing logic.
package can_pkg;
  typedef enum logic [1:0] {BTL_SYNC, BTL_SEG1, BTL_SEG2} btl_state_t;
  localparam int SJW_MAX = 4;
  localparam int TQ_W = 5;
  typedef logic [TQ_W-1:0] tq_t;
endpackage

// File: rtl/can_btl_if.sv
// can_btl_if: configuration, RX pin and timing strobes between bit timing and bit stream logic.
interface can_btl_if #(
  parameter int BRP_W  = 6,
  parameter int SEG1_W = 4,
  parameter int SEG2_W = 3
);
  logic [BRP_W-1:0]  brp;
  logic [SEG1_W-1:0] tseg1;
  logic [SEG2_W-1:0] tseg2;
  logic [1:0]        sjw;
  logic              rx_in;
  logic              hard_sync_en;
  logic              resync_en;
  logic              sample_point;
  logic              tx_point;
  logic              rx_sampled;
  logic              hard_synced;
  modport master (
    output brp, tseg1, tseg2, sjw, rx_in, hard_sync_en, resync_en,
    input  sample_point, tx_point, rx_sampled, hard_synced
  );
  modport slave (
    input  brp, tseg1, tseg2, sjw, rx_in, hard_sync_en, resync_en,
    output sample_point, tx_point, rx_sampled, hard_synced
  );
endinterface

// File: rtl/can_tq_prescaler.sv
// can_tq_prescaler: divides clk into time quanta; restart makes the current clk the first of a tq.
module can_tq_prescaler #(
  parameter int BRP_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BRP_W-1:0] i_brp,
  input  logic             i_restart,
  output logic             o_tq_end,
  output logic             o_cnt_zero
);
  logic [BRP_W-1:0] r_cnt, w_cnt;
  always_comb begin
    w_cnt      = i_restart ? '0 : r_cnt;
    o_tq_end   = w_cnt == i_brp;
    o_cnt_zero = r_cnt == '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= o_tq_end ? '0 : w_cnt + BRP_W'(1);
  end
endmodule

// File: rtl/can_btl.sv
// can_btl: CAN bit timing FSM with hard sync and SJW-limited resync.
module can_btl
  import can_pkg::*;
#(
  parameter int BRP_W = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  can_btl_if.slave bus
);
  btl_state_t r_state, w_state, w_state_n;
  tq_t  r_tq, r_ext, r_cut, w_tq_n, w_ext_n, w_cut_n, w_sjw1, w_rem, w_k1;
  logic r_early, r_flag, r_rx_prev, r_rx_sampled;
  logic w_tq_end, w_cnt_zero, w_edge, w_hard, w_bit_start, w_resync;
  logic w_early_n, w_seg1_last, w_seg2_last, w_sample;

  can_tq_prescaler #(.BRP_W(BRP_W)) u_pre (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_brp     (bus.brp),
    .i_restart (w_hard),
    .o_tq_end  (w_tq_end),
    .o_cnt_zero(w_cnt_zero)
  );

  // A hard sync makes this clk the first clk of SYNC, so w_state replaces r_state downstream.
  always_comb begin
    w_edge      = r_rx_prev & ~bus.rx_in & r_rx_sampled;
    w_hard      = bus.hard_sync_en & w_edge;
    w_bit_start = r_state == BTL_SYNC && w_cnt_zero;
    w_resync    = bus.resync_en & ~bus.hard_sync_en & w_edge & ~(r_flag & ~w_bit_start);
    w_state     = w_hard ? BTL_SYNC : r_state;
    w_sjw1      = tq_t'(bus.sjw) + tq_t'(1);
    w_k1        = r_tq + tq_t'(1);
    w_rem       = tq_t'(bus.tseg2) + tq_t'(1) - r_tq;
    w_ext_n     = w_hard ? '0 : (w_resync && r_state == BTL_SEG1) ? (w_k1 < w_sjw1 ? w_k1 : w_sjw1) : r_ext;
    w_cut_n     = w_hard ? '0 : (w_resync && r_state == BTL_SEG2 && w_rem > w_sjw1) ? w_sjw1 : r_cut;
    w_early_n   = !w_hard && (r_early || (w_resync && r_state == BTL_SEG2 && w_rem <= w_sjw1));
    w_seg1_last = r_tq == tq_t'(bus.tseg1) + w_ext_n;
    w_seg2_last = w_early_n || r_tq == tq_t'(bus.tseg2) - w_cut_n;
    w_state_n   = !w_tq_end ? w_state :
                  w_state == BTL_SYNC ? BTL_SEG1 :
                  w_state == BTL_SEG1 ? (w_seg1_last ? BTL_SEG2 : BTL_SEG1) :
                  (w_seg2_last ? BTL_SYNC : BTL_SEG2);
    w_tq_n      = (w_hard || w_state_n != w_state) ? '0 : w_tq_end ? w_k1 : r_tq;
    w_sample    = rst_n && w_tq_end && w_state == BTL_SEG1 && w_seg1_last;
    bus.sample_point = w_sample;
    bus.tx_point     = rst_n && (w_hard || w_bit_start);
    bus.hard_synced  = rst_n && w_hard;
    bus.rx_sampled   = r_rx_sampled;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= BTL_SYNC;
      r_tq         <= '0;
      r_ext        <= '0;
      r_cut        <= '0;
      r_early      <= 1'b0;
      r_flag       <= 1'b0;
      r_rx_prev    <= 1'b1;
      r_rx_sampled <= 1'b1;
    end else begin
      r_state   <= w_state_n;
      r_tq      <= w_tq_n;
      r_ext     <= w_state_n == BTL_SYNC ? '0 : w_ext_n;
      r_cut     <= w_state_n == BTL_SYNC ? '0 : w_cut_n;
      r_early   <= w_state_n != BTL_SYNC && w_early_n;
      r_flag    <= w_hard || w_resync || (r_flag && !w_bit_start);
      r_rx_prev <= bus.rx_in;
      if (w_sample) r_rx_sampled <= bus.rx_in;
    end
  end
endmodule

// File: tb/tb_can_btl.sv
// tb_can_btl: table-driven directed checks of CAN bit timing strobes and sync behaviour.
module tb_can_btl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  can_btl_if bus();
  can_btl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int sjw;
    bit hard;
    bit rsync;
    int e1;
    int rise;
    int e2;
    int exp_sp;
    int exp_tx;
    int exp_hs;
  } vec_t;

  vec_t vecs[11];

  function automatic logic rx_at(input vec_t v, input int c);
    logic r = 1'b1;
    if (v.e1 >= 0 && c >= v.e1) r = 1'b0;
    if (v.rise >= 0 && c >= v.rise) r = 1'b1;
    if (v.e2 >= 0 && c >= v.e2) r = 1'b0;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic start(input int brp_v, input int sjw_v, input bit hard, input bit rs, input string nm);
    bus.brp = 6'(brp_v);
    bus.tseg1 = 4'd5;
    bus.tseg2 = 3'd2;
    bus.sjw = 2'(sjw_v);
    bus.hard_sync_en = hard;
    bus.resync_en = rs;
    bus.rx_in = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, " rst tx"}, int'(bus.tx_point), 0);
    chk({nm, " rst sp"}, int'(bus.sample_point), 0);
    chk({nm, " rst hs"}, int'(bus.hard_synced), 0);
    chk({nm, " rst rxs"}, int'(bus.rx_sampled), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int sp = -1, tx2 = -1, hs = -1, both = 0, tx0 = 0, rs = -1;
    string nm = $sformatf("v%0d", idx);
    start(1, v.sjw, v.hard, v.rsync, nm);
    for (int c = 0; c < 30; c++) begin
      bus.rx_in = rx_at(v, c);
      @(negedge clk);
      if (c == 0) tx0 = int'(bus.tx_point);
      if (bus.tx_point && c > 0 && tx2 < 0) tx2 = c;
      if (bus.sample_point && sp < 0) sp = c;
      if (bus.hard_synced && hs < 0) hs = c;
      if (bus.tx_point && bus.sample_point) both++;
      if (c == v.exp_sp + 1) rs = int'(bus.rx_sampled);
      @(posedge clk);
      #1;
    end
    chk({nm, " tx0"}, tx0, 1);
    chk({nm, " sample_point"}, sp, v.exp_sp);
    chk({nm, " next tx_point"}, tx2, v.exp_tx);
    chk({nm, " hard_synced"}, hs, v.exp_hs);
    chk({nm, " tx&sp overlap"}, both, 0);
    chk({nm, " rx_sampled"}, rs, int'(rx_at(v, v.exp_sp)));
  endtask

  task automatic run_reset(input int at);
    int tx_after = 0, sp_at = -1;
    string nm = $sformatf("rst@%0d", at);
    start(1, 1, 1'b0, 1'b1, nm);
    for (int c = 0; c < at + 20; c++) begin
      rst_n = (c >= at && c < at + 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c == at || c == at + 1)
        chk($sformatf("%s strobes c%0d", nm, c), int'({bus.tx_point, bus.sample_point, bus.hard_synced}), 0);
      if (c == at + 2) tx_after = int'(bus.tx_point);
      if (c > at + 1 && bus.sample_point && sp_at < 0) sp_at = c;
      @(posedge clk);
      #1;
    end
    chk({nm, " tx after release"}, tx_after, 1);
    chk({nm, " sp after release"}, sp_at, at + 15);
  endtask

  initial begin
    //         sjw hard rs  e1  rise e2  sp  tx  hs
    vecs[0]  = '{1, 0, 1, -1, -1, -1, 13, 20, -1};
    vecs[1]  = '{1, 1, 1,  7, -1, -1, 20,  7,  7};
    vecs[2]  = '{1, 0, 1,  3, -1, -1, 15, 22, -1};
    vecs[3]  = '{1, 0, 1, 10, -1, -1, 17, 24, -1};
    vecs[4]  = '{1, 0, 1, 18, -1, -1, 13, 20, -1};
    vecs[5]  = '{0, 0, 1, 14, -1, -1, 13, 18, -1};
    vecs[6]  = '{1, 0, 1,  3,  5,  7, 15, 22, -1};
    vecs[7]  = '{1, 0, 1,  1, -1, -1, 13, 20, -1};
    vecs[8]  = '{1, 0, 0,  3, -1, -1, 13, 20, -1};
    vecs[9]  = '{1, 0, 1, 16, -1, -1, 13, 18, -1};
    vecs[10] = '{3, 0, 1, 10, -1, -1, 21, 28, -1};
    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);
    run_reset(9);
    run_reset(13);
    start(0, 1, 1'b0, 1'b1, "brp0");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("brp0 tx c%0d", c), int'(bus.tx_point), int'(c % 10 == 0));
      chk($sformatf("brp0 sp c%0d", c), int'(bus.sample_point), int'(c % 10 == 6));
      @(posedge clk);
      #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
